// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - run/pause/lost sequencer, step prescaler, spawning and scoring for two pipes
module pipe_scheduler #(
  parameter int TICK_DIV = 500000,
  parameter int X_START  = 1000,
  parameter int X_OFF    = 1023,
  parameter int Y_IDLE   = 75,
  parameter int SPACING  = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Lost,
  output logic [9:0] PipePosXA,
  output logic [9:0] PipePosYA,
  output logic [9:0] PipePosXB,
  output logic [9:0] PipePosYB,
  output logic       ActiveA,
  output logic       ActiveB,
  output logic       Tick,
  output logic [7:0] Score,
  output logic [1:0] GameState
);

  // A TICK_DIV of 1 still needs a one-bit counter that simply stays at zero.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0] X_START_V = 10'(X_START);
  localparam logic [9:0] X_OFF_V   = 10'(X_OFF);
  localparam logic [9:0] Y_IDLE_V  = 10'(Y_IDLE);
  // Pipe A position at which pipe B is launched; must be non-zero.
  localparam logic [9:0] X_LAUNCH  = 10'(X_START - SPACING);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LOST  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic          start_q, start_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [9:0]    xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
  logic          act_a_q, act_a_d, act_b_q, act_b_d;
  logic          tick_q, tick_d;
  logic [7:0]    score_q, score_d;

  logic          start_edge;
  logic [2:0]    spawn_idx;
  logic [1:0]    passed;
  logic [8:0]    score_sum;

  function automatic logic [9:0] gap_height(input logic [2:0] i);
    case (i)
      3'd0:    gap_height = 10'd300;
      3'd1:    gap_height = 10'd100;
      3'd2:    gap_height = 10'd210;
      3'd3:    gap_height = 10'd250;
      3'd4:    gap_height = 10'd170;
      3'd5:    gap_height = 10'd190;
      3'd6:    gap_height = 10'd230;
      default: gap_height = 10'd200;
    endcase
  endfunction

  assign start_edge = Start & ~start_q;

  // Next-state: game FSM, prescaler and the per-step pipe movement / spawning.
  always_comb begin
    state_d   = state_q;
    start_d   = Start;
    presc_d   = presc_q;
    idx_d     = idx_q;
    xa_d      = xa_q;
    ya_d      = ya_q;
    xb_d      = xb_q;
    yb_d      = yb_q;
    act_a_d   = act_a_q;
    act_b_d   = act_b_q;
    tick_d    = 1'b0;
    score_d   = score_q;
    spawn_idx = idx_q;
    passed    = 2'd0;
    score_sum = 9'd0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_RUN;
          xa_d    = X_START_V;
          ya_d    = gap_height(3'd0);
          act_a_d = 1'b1;
          idx_d   = 3'd1;
        end
      end
      ST_RUN: begin
        if (Lost) begin
          state_d = ST_LOST;
        end else if (Pause) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          // Spawns draw table entries in A-then-B order within one step.
          if (act_a_q) begin
            if (xa_q == 10'd0) begin
              xa_d      = X_START_V;
              ya_d      = gap_height(spawn_idx);
              spawn_idx = spawn_idx + 3'd1;
              passed    = passed + 2'd1;
            end else begin
              xa_d = xa_q - 10'd1;
            end
          end
          if (act_b_q) begin
            if (xb_q == 10'd0) begin
              xb_d      = X_START_V;
              yb_d      = gap_height(spawn_idx);
              spawn_idx = spawn_idx + 3'd1;
              passed    = passed + 2'd1;
            end else begin
              xb_d = xb_q - 10'd1;
            end
          end else if (xa_d == X_LAUNCH) begin
            // First launch of B is not a passed pipe, so it does not score.
            xb_d      = X_START_V;
            yb_d      = gap_height(spawn_idx);
            spawn_idx = spawn_idx + 3'd1;
            act_b_d   = 1'b1;
          end
          idx_d     = spawn_idx;
          score_sum = {1'b0, score_q} + {7'd0, passed};
          score_d   = score_sum[8] ? 8'd255 : score_sum[7:0];
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (Lost) begin
          state_d = ST_LOST;
        end else if (!Pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (start_edge) begin
          state_d = ST_IDLE;
          presc_d = '0;
          idx_d   = 3'd0;
          xa_d    = X_OFF_V;
          ya_d    = Y_IDLE_V;
          xb_d    = X_OFF_V;
          yb_d    = Y_IDLE_V;
          act_a_d = 1'b0;
          act_b_d = 1'b0;
          score_d = 8'd0;
        end
      end
    endcase
  end

  // State registers with asynchronous return to the idle picture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= 3'd0;
      xa_q    <= X_OFF_V;
      ya_q    <= Y_IDLE_V;
      xb_q    <= X_OFF_V;
      yb_q    <= Y_IDLE_V;
      act_a_q <= 1'b0;
      act_b_q <= 1'b0;
      tick_q  <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      act_a_q <= act_a_d;
      act_b_q <= act_b_d;
      tick_q  <= tick_d;
      score_q <= score_d;
    end
  end

  assign PipePosXA = xa_q;
  assign PipePosYA = ya_q;
  assign PipePosXB = xb_q;
  assign PipePosYB = yb_q;
  assign ActiveA   = act_a_q;
  assign ActiveB   = act_b_q;
  assign Tick      = tick_q;
  assign Score     = score_q;
  assign GameState = state_q;

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
- Game-level controller for the two scrolling pipes. Owns the run/pause/lost state machine, the pipe-speed prescaler, pipe spawning and staggering, height selection from a fixed table, and the passed-pipe score.
- Sits between the input/collision logic (Start, Pause, Lost) and the VGA renderer, which consumes the pipe X/Y outputs.
- Replaces the per-pipe free-running movers with one sequenced source.

Parameters:
- TICK_DIV, 500000: clock cycles per one-pixel pipe step.
- X_START, 1000: X written on spawn/respawn.
- X_OFF, 1023: X of an inactive (off-screen) pipe.
- Y_IDLE, 75: Y of an inactive pipe.
- SPACING, 500: pixels pipe A travels before pipe B first spawns.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  start button level; rising edge detected internally
- Pause  in  1  level; high holds the game
- Lost  in  1  collision flag from bird logic; level
- PipePosXA  out  10  pipe A left X
- PipePosYA  out  10  pipe A gap Y
- PipePosXB  out  10  pipe B left X
- PipePosYB  out  10  pipe B gap Y
- ActiveA  out  1  pipe A on screen
- ActiveB  out  1  pipe B on screen
- Tick  out  1  one-cycle pulse on each move step
- Score  out  8  pipes passed, saturating
- GameState  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LOST

Behaviour:
- Reset (async) or entry to IDLE:
  - X = X_OFF, Y = Y_IDLE, Active = 0 on both pipes.
  - Tick 0, Score 0, prescaler 0, height index 0, GameState IDLE, Start edge register 0.
- StartEdge = Start & ~Start_q. Start_q is registered every cycle in all states.
- Height table (index 0..7): 300, 100, 210, 250, 170, 190, 230, 200.
  - 3-bit index; wraps 7 -> 0.
  - Every spawn consumes table[idx] and then increments idx.
- IDLE:
  - StartEdge -> RUN.
  - On the same edge: A spawns (XA = X_START, YA = table[0], ActiveA = 1), idx = 1.
- RUN:
  - The prescaler increments each cycle. When it equals TICK_DIV-1 it clears, and on that edge the step is applied and Tick = 1 for exactly one cycle. The new positions are visible in the same cycle Tick is high.
  - Step, per active pipe: if X == 0, respawn (X = X_START, Y = table[idx], idx++, Score + 1 saturating at 255); else X = X - 1.
  - B launch: on a step where ActiveB = 0 and A's new XA == X_START - SPACING, B spawns at X_START with the next table entry. This launch does not score. B is never deactivated before IDLE.
  - Simultaneous spawns on one step: A takes idx, B takes idx+1, idx += 2, Score adds one per respawn (saturating).
  - Precedence: Lost > Pause > step.
  - Lost high -> LOST. No step is applied on that edge and the prescaler holds.
  - Pause high (Lost low) -> PAUSE. The prescaler holds its count and no step occurs.
- PAUSE:
  - All state frozen.
  - Lost -> LOST.
  - Pause low -> RUN; the prescaler resumes from the held count.
- LOST:
  - Positions, Score and idx frozen; Tick 0.
  - StartEdge -> IDLE, which applies the full IDLE initialisation on that edge.
  - Start held high from before LOST does not retrigger; a new rising edge is required.
- Tick is always 0 outside RUN.
- Widths:
  - Prescaler is ceil(log2(TICK_DIV)) bits.
  - X arithmetic is 10-bit; decrement only when X != 0, so it never wraps.
  - X_START - SPACING is evaluated at elaboration; it must be > 0.
- Reset asserted mid-game returns to IDLE values asynchronously. After release, a fresh StartEdge is needed to run.

Test Plan (TICK_DIV=4, X_START=20, SPACING=10, X_OFF=1023):
- Reset, then a Start pulse -> GameState 01, XA = 20, YA = 300, ActiveA = 1, B at (1023, 75). The first Tick comes 4 cycles later, with XA = 19.
- Run 10 ticks -> XA = 10; ActiveB rises on that tick with XB = 20, YB = 100. Neither launch scores, so Score stays 0.
- Run until XA = 0, then one more tick -> XA = 20, YA = 210, Score = 1. Continue until B wraps -> YB = 250, Score = 2. Let idx pass 7 -> the next spawn Y = 300.
- Raise Pause for 7 cycles midway between ticks -> X frozen, no Tick, GameState 10. Lower Pause -> the next Tick comes after the remaining prescaler count only.
- Assert Lost in the same cycle the prescaler hits 3 -> no step and no Tick, GameState 11, positions held. Hold Start high across LOST entry -> stays LOST. Drop Start, then raise it -> IDLE with all reset values.
- Force Score to 255 via a long run (or a TICK_DIV=1 build) -> the next respawn leaves Score = 255. Assert Reset asynchronously mid-tick -> outputs take IDLE values before the next Clk edge.
